// File: rtl/cin_feature_framer.sv
// cin_feature_framer: tags the channel-in feature stream with end-of-row/end-of-frame flags
// against a latched column/row geometry, behind a 2-entry skid buffer.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
module cin_feature_framer #(
  parameter int CHANNEL_IN_NUM = 16,
  parameter int WIDTH_COUNT = 12
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             Start,
  input  logic [WIDTH_COUNT-1:0]                           Col_Num,
  input  logic [WIDTH_COUNT-1:0]                           Row_Num,
  input  logic [`WIDTH_DATA*`PICTURE_NUM*CHANNEL_IN_NUM-1:0] S_Feature,
  input  logic                                             S_Valid,
  output logic                                             S_Ready,
  output logic [`WIDTH_DATA*`PICTURE_NUM*CHANNEL_IN_NUM-1:0] M_Feature,
  output logic                                             M_Valid,
  input  logic                                             M_Ready,
  output logic                                             M_Last_Col,
  output logic                                             M_Last_Row,
  output logic                                             Busy,
  output logic                                             Done
);
  localparam int DW = `WIDTH_DATA*`PICTURE_NUM*CHANNEL_IN_NUM;
  localparam logic [WIDTH_COUNT-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state;
  logic [WIDTH_COUNT-1:0] r_col_n, r_row_n, r_col_cnt, r_row_cnt;
  logic [DW+1:0] r_e0, r_e1;
  logic [1:0] r_cnt;
  logic r_done;
  logic w_push, w_pop, w_last_col, w_last_row;
  logic [DW+1:0] w_in;
  assign S_Ready = (r_state == RUN) && (r_cnt != 2'd2);
  assign M_Valid = r_cnt != 2'd0;
  assign {M_Feature, M_Last_Col, M_Last_Row} = r_e0;
  assign Busy = r_state != IDLE;
  assign Done = r_done;
  assign w_push = S_Valid && S_Ready;
  assign w_pop = M_Valid && M_Ready;
  assign w_last_col = r_col_cnt == r_col_n - ONE;
  assign w_last_row = w_last_col && (r_row_cnt == r_row_n - ONE);
  assign w_in = {S_Feature, w_last_col, w_last_row};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_col_n <= '0;
      r_row_n <= '0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_e0 <= '0;
      r_e1 <= '0;
      r_cnt <= 2'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      // head always holds the oldest beat; the second slot only fills when the head is stalled
      if (w_pop && r_cnt == 2'd2) r_e0 <= r_e1;
      else if (w_push && (r_cnt == 2'd0 || w_pop)) r_e0 <= w_in;
      if (w_push && r_cnt == 2'd1 && !w_pop) r_e1 <= w_in;
      case (r_state)
        IDLE: if (Start) begin
          if (Col_Num != '0 && Row_Num != '0) begin
            r_col_n <= Col_Num;
            r_row_n <= Row_Num;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_state <= RUN;
          end else r_done <= 1'b1;
        end
        RUN: if (w_push) begin
          r_col_cnt <= w_last_col ? '0 : r_col_cnt + ONE;
          r_row_cnt <= w_last_row ? '0 : w_last_col ? r_row_cnt + ONE : r_row_cnt;
          if (w_last_row) r_state <= DRAIN;
        end
        DRAIN: if (w_pop && r_cnt == 2'd1) begin
          r_state <= IDLE;
          r_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cin_feature_framer.sv
// tb_cin_feature_framer: randomized scenarios checked against a queue-based frame model.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
module tb_cin_feature_framer;
  localparam int DW = `WIDTH_DATA*`PICTURE_NUM*16;
  localparam int CW = 12;
  typedef struct {logic [DW-1:0] d; logic lc; logic lr;} beat_t;
  logic clk = 0, rst = 1, Start = 0, S_Valid = 0, M_Ready = 0;
  logic [CW-1:0] Col_Num = 0, Row_Num = 0;
  logic [DW-1:0] S_Feature = 0, M_Feature;
  logic S_Ready, M_Valid, M_Last_Col, M_Last_Row, Busy, Done;
  int n_cmp = 0, n_err = 0;
  beat_t q[$];
  always #5 clk = ~clk;
  cin_feature_framer #(.CHANNEL_IN_NUM(16), .WIDTH_COUNT(CW)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Col_Num(Col_Num), .Row_Num(Row_Num),
    .S_Feature(S_Feature), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .M_Feature(M_Feature), .M_Valid(M_Valid), .M_Ready(M_Ready),
    .M_Last_Col(M_Last_Col), .M_Last_Row(M_Last_Row), .Busy(Busy), .Done(Done));

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) v = (v << 32) | DW'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({S_Ready, M_Valid, M_Last_Col, M_Last_Row, Busy, Done} !== 6'b0 || M_Feature !== '0) begin
      n_err++;
      $display("FAIL reset: outputs sr=%b mv=%b lc=%b lr=%b busy=%b done=%b feat=%h, required all 0",
               S_Ready, M_Valid, M_Last_Col, M_Last_Row, Busy, Done, M_Feature);
    end
    rst = 0;
  endtask

  // mode 0: always valid/ready, 1: random, 2: M_Ready pattern 1,0,0,1
  task automatic run_frame(input int cols, input int rows, input int mode, input bit inject);
    int acc = 0, pops = 0, total = cols * rows, cyc = 0, dones = 0, done_cyc = 0;
    int last_pop = -10, lat_cyc = -1;
    bit stalled = 0;
    logic [DW+1:0] held = '0;
    logic [DW-1:0] cur = rnd_data();
    beat_t e;
    q.delete();
    @(negedge clk);
    Start = 1; Col_Num = CW'(cols); Row_Num = CW'(rows); S_Valid = 0; M_Ready = 0;
    @(negedge clk);
    Start = 0; Col_Num = CW'($urandom); Row_Num = CW'($urandom);
    forever begin
      if (stalled) begin
        n_cmp++;
        if (M_Valid !== 1'b1 || {M_Feature, M_Last_Col, M_Last_Row} !== held) begin
          n_err++;
          $display("FAIL stall_hold cyc=%0d: mv=%b data=%h, required mv=1 data=%h", cyc, M_Valid,
                   {M_Feature, M_Last_Col, M_Last_Row}, held);
        end
      end
      if (cyc == lat_cyc) begin
        n_cmp++;
        if (M_Valid !== 1'b1) begin
          n_err++;
          $display("FAIL latency cyc=%0d: mv=%b, required 1", cyc, M_Valid);
        end
      end
      n_cmp++;
      if (S_Ready !== (acc < total && q.size() < 2) || M_Valid !== (q.size() != 0)
          || Busy !== (acc < total || q.size() != 0)) begin
        n_err++;
        $display("FAIL flow cyc=%0d: sr=%b mv=%b busy=%b, required sr=%b mv=%b busy=%b", cyc, S_Ready,
                 M_Valid, Busy, acc < total && q.size() < 2, q.size() != 0, acc < total || q.size() != 0);
      end
      if (Done) begin
        dones++;
        done_cyc = cyc;
        n_cmp++;
        if (cyc != last_pop + 1 || acc != total || q.size() != 0) begin
          n_err++;
          $display("FAIL done_timing cyc=%0d: last_pop=%0d acc=%0d q=%0d, required cyc=last_pop+1 acc=%0d q=0",
                   cyc, last_pop, acc, q.size(), total);
        end
      end
      if (dones > 0 && cyc >= done_cyc + 3) break;
      if (cyc >= 3000) begin
        n_err++;
        $display("FAIL timeout: frame %0dx%0d did not finish, acc=%0d pops=%0d", cols, rows, acc, pops);
        break;
      end
      S_Valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      S_Feature = cur;
      M_Ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : (cyc % 4 == 0 || cyc % 4 == 3);
      if (inject && cyc == 4) begin
        Start = 1; Col_Num = CW'(cols + 1); Row_Num = CW'(rows + 2);
      end else Start = 0;
      if (M_Valid && M_Ready) begin
        pops++;
        last_pop = cyc;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL beat_extra cyc=%0d: output beat with empty model, required none", cyc);
        end else begin
          e = q.pop_front();
          if (M_Feature !== e.d || M_Last_Col !== e.lc || M_Last_Row !== e.lr) begin
            n_err++;
            $display("FAIL beat cyc=%0d: got %h lc=%b lr=%b, required %h lc=%b lr=%b", cyc, M_Feature,
                     M_Last_Col, M_Last_Row, e.d, e.lc, e.lr);
          end
        end
      end
      if (S_Valid && S_Ready) begin
        if (!M_Valid) lat_cyc = cyc + 1;
        e.d = cur; e.lc = (acc % cols) == cols - 1; e.lr = acc == total - 1;
        q.push_back(e);
        acc++;
        cur = rnd_data();
      end
      stalled = M_Valid && !M_Ready;
      held = {M_Feature, M_Last_Col, M_Last_Row};
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (acc != total || pops != total || dones != 1) begin
      n_err++;
      $display("FAIL frame_count %0dx%0d: acc=%0d pops=%0d dones=%0d, required %0d/%0d/1",
               cols, rows, acc, pops, dones, total, total);
    end
    if (mode == 0) begin
      n_cmp++;
      if (last_pop != total) begin
        n_err++;
        $display("FAIL throughput: last beat at cyc %0d, required %0d", last_pop, total);
      end
    end
    S_Valid = 0; M_Ready = 0; Start = 0;
  endtask

  task automatic test_basic();
    run_frame(4, 3, 0, 0);
  endtask

  task automatic test_backpressure();
    run_frame(3, 2, 2, 0);
    repeat (3) run_frame($urandom_range(1, 6), $urandom_range(1, 4), 1, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(5, 2, 0, 0);
    run_frame(2, 1, 0, 0);
    run_frame(1, 1, 1, 0);
  endtask

  task automatic test_zero_size();
    int dones = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      Start = 1; S_Valid = 1; M_Ready = 1;
      Col_Num = (k == 0) ? CW'(0) : CW'(3); Row_Num = (k == 0) ? CW'(5) : CW'(0);
      @(negedge clk);
      Start = 0;
      n_cmp++;
      if (Done !== 1'b1) begin
        n_err++;
        $display("FAIL zero_done k=%0d: done=%b, required 1", k, Done);
      end
      for (int c = 0; c < 4; c++) begin
        if (Done) dones++;
        n_cmp++;
        if (S_Ready !== 1'b0 || M_Valid !== 1'b0 || Busy !== 1'b0) begin
          n_err++;
          $display("FAIL zero_idle k=%0d: sr=%b mv=%b busy=%b, required 0/0/0", k, S_Ready, M_Valid, Busy);
        end
        @(negedge clk);
      end
    end
    n_cmp++;
    if (dones != 2) begin
      n_err++;
      $display("FAIL zero_pulses: %0d Done cycles, required 2", dones);
    end
    S_Valid = 0; M_Ready = 0;
  endtask

  task automatic test_reset_mid();
    int acc = 0, pops = 0;
    @(negedge clk);
    Start = 1; Col_Num = 4; Row_Num = 3;
    @(negedge clk);
    Start = 0;
    for (int c = 0; c < 50; c++) begin
      if (acc == 5 && acc - pops == 2) break;
      S_Valid = 1; S_Feature = rnd_data(); M_Ready = pops < 3;
      if (M_Valid && M_Ready) pops++;
      if (S_Valid && S_Ready) acc++;
      @(negedge clk);
    end
    n_cmp++;
    if (acc != 5 || M_Valid !== 1'b1 || S_Ready !== 1'b0) begin
      n_err++;
      $display("FAIL pre_reset: acc=%0d pops=%0d mv=%b sr=%b, required acc=5 pops=3 mv=1 sr=0",
               acc, pops, M_Valid, S_Ready);
    end
    rst = 1; S_Valid = 0; M_Ready = 0;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (M_Valid !== 1'b0 || S_Ready !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid c=%0d: mv=%b sr=%b busy=%b done=%b, required 0/0/0/0",
                 c, M_Valid, S_Ready, Busy, Done);
      end
      @(negedge clk);
    end
    run_frame(4, 3, 1, 0);
  endtask

  task automatic test_start_ignored();
    run_frame(4, 3, 0, 1);
    run_frame(4, 3, 1, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_zero_size();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
